id_ex_register: RTL
===================

# id_ex_register

ID/EX pipeline register for the pipelined CPU. It captures decoded operands, register addresses and control from the ID stage and holds them stable for EX. At capture it decodes ALUOp/funct into the 3-bit ALU control code, so the ALU receives `ALUCtrl` straight from a flop. It supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- `DATA_W`, 32, operand/immediate width
- `ADDR_W`, 5, register-file address width
- `clk_i` in 1: the only clock; all state updates on the rising edge
- `rst_i` in 1: synchronous, active-high reset; sampled on the `clk_i` rising edge
- `stall_i` in 1: hold all stored contents this cycle
- `flush_i` in 1: load a bubble this cycle
- `valid_i` in 1: the ID stage holds a real instruction
- `rs_data_i`, `rt_data_i` in DATA_W: register-file read data
- `imm_i` in DATA_W: sign-extended immediate
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i` in ADDR_W: source and destination register numbers
- `funct_i` in 6: instruction[5:0]
- `ALUOp_i` in 2: main-control ALU class
- `RegDst_i`, `ALUSrc_i`, `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i` in 1: main-control signals
- `valid_o` out 1: EX holds a real instruction
- `rs_data_o`, `rt_data_o`, `imm_o` out DATA_W: latched operands
- `rs_addr_o`, `rt_addr_o` out ADDR_W: latched source numbers, used by forwarding
- `wr_addr_o` out ADDR_W: resolved destination register
- `ALUCtrl_o` out 3: ALU operation code
- `ALUSrc_o`, `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o` out 1: latched control
- `illegal_o` out 1: the latched instruction is R-type with an unsupported funct

## Operation
- Per-edge priority: `rst_i` > `flush_i` > `stall_i` > load.
- **Reset:** every output is 0, including `ALUCtrl_o` = 3'b000 and `valid_o` = 0.
- **Flush:** same values as reset. This is the bubble state.
- **Stall:** every output keeps its value. `valid_i` is ignored.
- **Load:** every `*_o` takes its `*_i` counterpart, with these exceptions:
  - `wr_addr_o` = `RegDst_i` ? `rd_addr_i` : `rt_addr_i`.
  - `ALUCtrl_o` is decoded from `ALUOp_i`/`funct_i` as listed below.
  - If `valid_i` = 0, all control outputs, `valid_o` and `illegal_o` load 0. Data and address fields still load.
- ALU control decode:
  - `ALUOp` 00 -> 010 (add: lw, sw, addi)
  - `ALUOp` 01 -> 110 (sub: beq)
  - `ALUOp` 11 -> 001 (or: ori)
  - `ALUOp` 10, R-type, by funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 011000 -> 011 (mul; gated by the macro)
- Unsupported R-type funct:
  - `ALUCtrl_o` = 010.
  - `RegWrite_o`, `MemRead_o`, `MemWrite_o` = 0.
  - `illegal_o` = `valid_i`.
- No arithmetic is performed in this block. Widths pass through unchanged.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are registered. There are no combinational input-to-output paths.
- A stall held for k cycles holds the outputs for k cycles. The first edge without stall loads the current inputs.
- `flush_i` and `stall_i` both high: a bubble is loaded and the stall is ignored.
- Reset asserted mid-stall or mid-flush: the outputs are 0 at the next edge, regardless of the other inputs.
- `illegal_o` is a registered level tied to the latched instruction. It holds during a stall and clears on flush.

## Configuration
- `ID_EX_MUL_EN` defined: funct 011000 decodes to `ALUCtrl_o` = 011 and is treated as a legal instruction.
- `ID_EX_MUL_EN` undefined: funct 011000 is handled as an unsupported funct (`ALUCtrl_o` = 010, write/memory controls cleared, `illegal_o` = 1).
- No other behaviour changes with the macro.

## Test plan
- Reset for 2 edges with all inputs at random values -> every output is 0. Then load `add $3,$1,$2` (`ALUOp` 10, funct 100000, `RegDst` 1, rd 3) -> next cycle `ALUCtrl_o` = 010, `wr_addr_o` = 3, `RegWrite_o` = 1, `valid_o` = 1.
- Load `sub`, then assert `stall_i` for 3 cycles while the inputs change to `and` -> `ALUCtrl_o` stays 110 for 3 cycles. On the first unstalled edge it becomes 000.
- Assert `flush_i` and `stall_i` together while `lw` (`ALUOp` 00, `MemRead` 1) is presented -> the next cycle shows all controls 0 and `valid_o` = 0.
- `ALUOp` 10 with funct 011000, `rs_data_i` = 6, `rt_data_i` = 7:
  - with `ID_EX_MUL_EN` -> `ALUCtrl_o` = 011, `illegal_o` = 0;
  - without it -> `ALUCtrl_o` = 010, `RegWrite_o` = 0, `illegal_o` = 1.
- `ori` (`ALUOp` 11, `ALUSrc` 1, `RegDst` 0, rt 5, `imm_i` = 0x0000_00FF) -> `ALUCtrl_o` = 001, `wr_addr_o` = 5, `imm_o` = 0xFF. With `valid_i` = 0 instead -> `RegWrite_o` = 0 while `imm_o` still loads 0xFF.
- Assert `rst_i` during an active stall holding a valid `or` -> the outputs are 0 after that edge.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: latches ID-stage operands/control for EX and pre-decodes ALUCtrl.
// Optional feature: define ID_EX_MUL_EN to accept R-type funct 011000 (mul, ALUCtrl 011).
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [5:0]        funct_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              RegDst_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [ADDR_W-1:0] rs_addr_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [2:0]        ALUCtrl_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        alu_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
  } stage_t;

  stage_t st_q, st_d;
  logic [2:0] alu_dec;
  logic       legal;

  always_comb begin
    alu_dec = 3'b010;
    legal   = 1'b1;
    unique case (ALUOp_i)
      2'b00: alu_dec = 3'b010;
      2'b01: alu_dec = 3'b110;
      2'b11: alu_dec = 3'b001;
      default: begin
        case (funct_i)
          6'b100000: alu_dec = 3'b010;
          6'b100010: alu_dec = 3'b110;
          6'b100100: alu_dec = 3'b000;
          6'b100101: alu_dec = 3'b001;
`ifdef ID_EX_MUL_EN
          6'b011000: alu_dec = 3'b011;
`endif
          default: begin
            alu_dec = 3'b010;
            legal   = 1'b0;
          end
        endcase
      end
    endcase
  end

  // Data/address fields always load; control is gated so a non-instruction
  // or an unsupported funct can never write state downstream.
  always_comb begin
    st_d            = '0;
    st_d.valid      = valid_i;
    st_d.rs_data    = rs_data_i;
    st_d.rt_data    = rt_data_i;
    st_d.imm        = imm_i;
    st_d.rs_addr    = rs_addr_i;
    st_d.rt_addr    = rt_addr_i;
    st_d.wr_addr    = RegDst_i ? rd_addr_i : rt_addr_i;
    st_d.alu_ctrl   = valid_i ? alu_dec : 3'b000;
    st_d.alu_src    = valid_i & ALUSrc_i;
    st_d.reg_write  = valid_i & legal & RegWrite_i;
    st_d.mem_to_reg = valid_i & MemtoReg_i;
    st_d.mem_read   = valid_i & legal & MemRead_i;
    st_d.mem_write  = valid_i & legal & MemWrite_i;
    st_d.illegal    = valid_i & ~legal;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) st_q <= '0;
    else if (!stall_i)    st_q <= st_d;
  end

  assign valid_o    = st_q.valid;
  assign rs_data_o  = st_q.rs_data;
  assign rt_data_o  = st_q.rt_data;
  assign imm_o      = st_q.imm;
  assign rs_addr_o  = st_q.rs_addr;
  assign rt_addr_o  = st_q.rt_addr;
  assign wr_addr_o  = st_q.wr_addr;
  assign ALUCtrl_o  = st_q.alu_ctrl;
  assign ALUSrc_o   = st_q.alu_src;
  assign RegWrite_o = st_q.reg_write;
  assign MemtoReg_o = st_q.mem_to_reg;
  assign MemRead_o  = st_q.mem_read;
  assign MemWrite_o = st_q.mem_write;
  assign illegal_o  = st_q.illegal;

endmodule
